multicycle_ctrl: RTL

Multi-cycle control FSM that drives the control inputs of the 16-bit datapath: PCSrc, RegSrc, RegEn, ALUSrc, ALUOp, DmemWr and WrSrc.
- Consumes the datapath's opcode field (Inst = instruction[15:11]) and its IsZero flag.
- Sequences each instruction over 3–5 cycles: FETCH / DECODE / EXEC / MEM / WB.
- Adds PC and IR write enables for the multi-cycle datapath variant, plus run/step/halt debug control and a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/ctrl_decode.sv | 55 +++++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller:
// opcodes, ALU functions, FSM states and instruction classes.
package ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLT  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_LW   = 5'b01001;
  localparam logic [4:0] OP_SW   = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b01100;
  localparam logic [4:0] OP_BNE  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_ADDI,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_src;
    logic       wr_src;
    logic       br_ne;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: class, ALU function
// and datapath selects for one 5-bit opcode.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{
      cls:     C_ILLEGAL,
      alu_op:  ALU_ADD,
      alu_src: 1'b0,
      reg_src: 1'b0,
      wr_src:  1'b0,
      br_ne:   1'b0
    };
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        dec_o.cls     = C_RTYPE;
        dec_o.reg_src = 1'b1;
        dec_o.wr_src  = 1'b1;
        case (op_i)
          OP_SUB:  dec_o.alu_op = ALU_SUB;
          OP_AND:  dec_o.alu_op = ALU_AND;
          OP_OR:   dec_o.alu_op = ALU_OR;
          OP_SLT:  dec_o.alu_op = ALU_SLT;
          default: dec_o.alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        dec_o.cls     = C_ADDI;
        dec_o.alu_src = 1'b1;
        dec_o.wr_src  = 1'b1;
      end
      OP_LW: begin
        dec_o.cls     = C_LOAD;
        dec_o.alu_src = 1'b1;
      end
      OP_SW: begin
        dec_o.cls     = C_STORE;
        dec_o.alu_src = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.cls    = C_BRANCH;
        dec_o.alu_op = ALU_SUB;
        dec_o.br_ne  = op_i[0];
      end
      OP_HALT: dec_o.cls = C_HALT;
      default: dec_o.cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit datapath with
// run/step/halt debug control and a retired counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [4:0]       Inst,
  input  logic             IsZero,
  output logic             PCSrc,
  output logic             PCEn,
  output logic             IRWr,
  output logic             RegSrc,
  output logic             RegEn,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic             DmemWr,
  output logic             WrSrc,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [RET_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic             single_q, single_d;
  logic             illegal_q, illegal_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic [4:0] dec_op;
  dec_t       dec;
  logic       sel;
  logic       done;

  // Only DECODE looks at the live opcode; later states use the latch.
  assign dec_op = (state_q == S_DECODE) ? Inst : op_q;

  ctrl_decode u_decode (
    .op_i  (dec_op),
    .dec_o (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      single_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      single_q  <= single_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    single_d  = single_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    sel       = 1'b0;
    done      = 1'b0;
    PCSrc     = 1'b0;
    PCEn      = 1'b0;
    IRWr      = 1'b0;
    RegSrc    = 1'b0;
    RegEn     = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALU_ADD;
    DmemWr    = 1'b0;
    WrSrc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end
      end
      S_FETCH: begin
        IRWr    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = Inst;
        if (dec.cls == C_HALT) begin
          state_d = S_HALTED;
        end else if (dec.cls == C_ILLEGAL) begin
          state_d   = S_HALTED;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        sel = 1'b1;
        case (dec.cls)
          C_BRANCH: begin
            PCSrc = IsZero ^ dec.br_ne;
            done  = 1'b1;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        sel = 1'b1;
        if (dec.cls == C_STORE) begin
          DmemWr = 1'b1;
          done   = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        sel   = 1'b1;
        RegEn = 1'b1;
        done  = 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (sel) begin
      RegSrc = dec.reg_src;
      ALUSrc = dec.alu_src;
      ALUOp  = dec.alu_op;
      WrSrc  = dec.wr_src;
    end

    // Completion: advance the PC, count, and pick the next fetch.
    if (done) begin
      PCEn      = 1'b1;
      retired_d = retired_q + RET_W'(1);
      state_d   = (run && !single_q) ? S_FETCH : S_IDLE;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted  = (state_q == S_HALTED);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
